// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: default widths, the Q2 twiddle unit value
// and helpers giving the signed range of an N-bit value.
package fft_pkg;
  localparam int DW_DEF   = 33;
  localparam int TW_DEF   = 16;
  localparam int FRAC_DEF = TW_DEF - 2;

  localparam longint TW_ONE = longint'(1) << (TW_DEF - 2);

  function automatic longint sat_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction
endpackage

// File: rtl/cmult_round_sat.sv
// Rounds a full-precision sum half toward +inf, drops FRAC bits and clamps
// to OW-bit signed range, flagging any clamp.
module cmult_round_sat import fft_pkg::*; #(
  parameter int IW   = 50,
  parameter int OW   = 33,
  parameter int FRAC = 14
) (
  input  logic signed [IW-1:0] val_i,
  output logic signed [OW-1:0] res_o,
  output logic                 sat_o
);
  localparam int RW = IW + 1 - FRAC;
  localparam logic signed [IW:0]   HALF    = (IW + 1)'(longint'(1) << (FRAC - 1));
  localparam logic signed [RW-1:0] MAX_R   = RW'(sat_max(OW));
  localparam logic signed [RW-1:0] MIN_R   = RW'(sat_min(OW));
  localparam logic signed [OW-1:0] MAX_OUT = OW'(sat_max(OW));
  localparam logic signed [OW-1:0] MIN_OUT = OW'(sat_min(OW));

  logic signed [IW:0]   biased;
  logic signed [RW-1:0] shifted;

  // One guard bit above the input so the rounding constant can never wrap.
  assign biased  = {val_i[IW-1], val_i} + HALF;
  assign shifted = RW'(biased >>> FRAC);

  always_comb begin
    res_o = shifted[OW-1:0];
    sat_o = 1'b0;
    if (shifted > MAX_R) begin
      res_o = MAX_OUT;
      sat_o = 1'b1;
    end else if (shifted < MIN_R) begin
      res_o = MIN_OUT;
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/fft_cmult_pipe.sv
// Three-stage complex multiplier (sample x twiddle, optional conj) with
// round/saturate back to sample width and a sticky overflow flag.
module fft_cmult_pipe import fft_pkg::*; #(
  parameter int DW   = DW_DEF,
  parameter int TW   = TW_DEF,
  parameter int FRAC = TW - 2
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic signed [DW-1:0] IN_RE,
  input  logic signed [DW-1:0] IN_IM,
  input  logic signed [TW-1:0] W_RE,
  input  logic signed [TW-1:0] W_IM,
  input  logic                 CONJ,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic signed [DW-1:0] OUT_RE,
  output logic signed [DW-1:0] OUT_IM,
  output logic                 OVF,
  input  logic                 CLR
);
  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam logic signed [TW-1:0] W_MAX = TW'(sat_max(TW));
  localparam logic signed [TW-1:0] W_MIN = TW'(sat_min(TW));

  // Handshake: a beat moves on VALID & READY. The whole pipe advances only
  // when the output slot is empty or being drained, so IN_READY is that enable.
  logic en;
  assign en       = OUT_READY | ~OUT_VALID;
  assign IN_READY = en;

  logic                 s1_valid_q, s2_valid_q, out_valid_q;
  logic signed [DW-1:0] s1_re_q, s1_im_q;
  logic signed [TW-1:0] s1_wre_q, s1_wim_q, s1_wim_d;
  logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [SW-1:0] sum_re_d, sum_im_d;
  logic signed [DW-1:0] out_re_q, out_im_q, out_re_d, out_im_d;
  logic                 sat_re, sat_im;
  logic                 ovf_q, ovf_d;

  // Negating the most negative twiddle would wrap, so it clamps instead.
  always_comb begin
    s1_wim_d = W_IM;
    if (CONJ) s1_wim_d = (W_IM == W_MIN) ? W_MAX : -W_IM;
  end

  always_comb begin
    p_rr_d = PW'(s1_re_q) * PW'(s1_wre_q);
    p_ii_d = PW'(s1_im_q) * PW'(s1_wim_q);
    p_ri_d = PW'(s1_re_q) * PW'(s1_wim_q);
    p_ir_d = PW'(s1_im_q) * PW'(s1_wre_q);
  end

  always_comb begin
    sum_re_d = SW'(p_rr_q) - SW'(p_ii_q);
    sum_im_d = SW'(p_ri_q) + SW'(p_ir_q);
  end

  cmult_round_sat #(.IW(SW), .OW(DW), .FRAC(FRAC)) u_rs_re (
    .val_i (sum_re_d),
    .res_o (out_re_d),
    .sat_o (sat_re)
  );

  cmult_round_sat #(.IW(SW), .OW(DW), .FRAC(FRAC)) u_rs_im (
    .val_i (sum_im_d),
    .res_o (out_im_d),
    .sat_o (sat_im)
  );

  // A saturation entering stage 3 beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (CLR) ovf_d = 1'b0;
    if (en && s2_valid_q && (sat_re || sat_im)) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        s1_valid_q  <= IN_VALID;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_re_q <= out_re_d;
          out_im_q <= out_im_d;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (en) begin
      if (IN_VALID) begin
        s1_re_q  <= IN_RE;
        s1_im_q  <= IN_IM;
        s1_wre_q <= W_RE;
        s1_wim_q <= s1_wim_d;
      end
      if (s1_valid_q) begin
        p_rr_q <= p_rr_d;
        p_ii_q <= p_ii_d;
        p_ri_q <= p_ri_d;
        p_ir_q <= p_ir_d;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_RE    = out_re_q;
  assign OUT_IM    = out_im_q;
  assign OVF       = ovf_q;
endmodule

// File: tb/tb_fft_cmult_pipe.sv
// Directed bench for fft_cmult_pipe: hand-computed vectors, scoreboard queue
// checked by an output monitor, backpressure and mid-stream reset.
module tb_fft_cmult_pipe;
  localparam int DW = 33;
  localparam int TW = 16;
  localparam longint MAXV = (longint'(1) << 32) - 1;
  localparam longint MINV = -(longint'(1) << 32);

  logic                 CLK, RST_X;
  logic                 IN_VALID, IN_READY;
  logic signed [DW-1:0] IN_RE, IN_IM;
  logic signed [TW-1:0] W_RE, W_IM;
  logic                 CONJ;
  logic                 OUT_VALID, OUT_READY;
  logic signed [DW-1:0] OUT_RE, OUT_IM;
  logic                 OVF, CLR;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int out_seen = 0;
  bit lat_on = 0;

  logic [2*DW-1:0] exp_q[$];
  int              acc_q[$];
  logic [2*DW-1:0] mon_e;
  int              mon_a;

  fft_cmult_pipe #(.DW(DW), .TW(TW), .FRAC(TW - 2)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_RE     (IN_RE),
    .IN_IM     (IN_IM),
    .W_RE      (W_RE),
    .W_IM      (W_IM),
    .CONJ      (CONJ),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_RE    (OUT_RE),
    .OUT_IM    (OUT_IM),
    .OVF       (OVF),
    .CLR       (CLR)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // driver: present one beat, hold until accepted, queue its expected result
  task automatic send(input longint re, input longint im, input longint wre,
                      input longint wim, input logic conj,
                      input longint er, input longint ei);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    IN_VALID = 1'b1;
    IN_RE = DW'(re);
    IN_IM = DW'(im);
    W_RE = TW'(wre);
    W_IM = TW'(wim);
    CONJ = conj;
    while (!acc && g < 50) begin
      @(negedge CLK);
      acc = IN_READY;
      if (acc) begin
        exp_q.push_back({DW'(er), DW'(ei)});
        acc_q.push_back(cyc);
      end
      @(posedge CLK);
      #1;
      g++;
    end
    if (!acc) check("send_timeout", 0, 1);
    IN_VALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge CLK);
      g++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_clr();
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
  endtask

  // scoreboard: every accepted output is compared against the queue head
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", OUT_VALID, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        rx_cnt++;
        check($sformatf("out_re#%0d", rx_cnt), $signed(OUT_RE), $signed(mon_e[2*DW-1:DW]));
        check($sformatf("out_im#%0d", rx_cnt), $signed(OUT_IM), $signed(mon_e[DW-1:0]));
        if (lat_on) check($sformatf("latency#%0d", rx_cnt), cyc - mon_a, 3);
      end
    end
  end

  initial begin
    int rx_before;
    int seen_before;
    logic signed [DW-1:0] hold_re;

    RST_X = 1'b0;
    IN_VALID = 1'b0;
    IN_RE = '0;
    IN_IM = '0;
    W_RE = '0;
    W_IM = '0;
    CONJ = 1'b0;
    OUT_READY = 1'b1;
    CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_out_re", OUT_RE, 0);
    check("rst_out_im", OUT_IM, 0);
    check("rst_ovf", OVF, 0);
    check("rst_in_ready", IN_READY, 1);
    RST_X = 1'b1;
    @(posedge CLK);
    #1;

    // identity, rotation, conj, rounding, conj of most-negative twiddle
    lat_on = 1'b1;
    send(1000, -2000, 16384, 0, 1'b0, 1000, -2000);
    drain("drain_ident");
    check("ovf_ident", OVF, 0);
    send(500, 300, 0, 16384, 1'b0, -300, 500);
    send(500, 300, 0, 16384, 1'b1, 300, -500);
    send(1, 0, 8192, 0, 1'b0, 1, 0);
    send(-1, 0, 8192, 0, 1'b0, 0, 0);
    send(3, 0, -8192, 0, 1'b0, -1, 0);
    send(0, 16384, 0, -32768, 1'b1, -32767, 0);
    send(0, 16384, 0, -32768, 1'b0, 32768, 0);
    drain("drain_dir");
    check("ovf_dir", OVF, 0);

    // saturation and sticky overflow
    send(MAXV, MAXV, 16384, -16384, 1'b0, MAXV, 0);
    drain("drain_sat");
    check("ovf_sat", OVF, 1);
    send(1000, -2000, 16384, 0, 1'b0, 1000, -2000);
    drain("drain_sticky");
    check("ovf_sticky", OVF, 1);
    pulse_clr();
    check("ovf_clr", OVF, 0);
    send(MAXV, 0, -32768, 0, 1'b0, MINV, 0);
    drain("drain_negsat");
    check("ovf_negsat", OVF, 1);
    pulse_clr();
    check("ovf_clr2", OVF, 0);

    // clear pulsed on the very edge a saturating result enters stage 3
    send(MINV, 0, -16384, 0, 1'b0, MAXV, 0);
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    check("ovf_set_wins", OVF, 1);
    drain("drain_setwins");

    // backpressure: 8 back-to-back beats, output stalled for 4 cycles
    lat_on = 1'b0;
    rx_before = rx_cnt;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          longint r, i;
          r = 1000 + 111 * k;
          i = -50 * k;
          if (k % 2 == 0) send(r, i, 16384, 0, 1'b0, r, i);
          else            send(r, i, 0, 16384, 1'b0, -i, r);
        end
      end
      begin
        repeat (4) @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        hold_re = OUT_RE;
        for (int s = 0; s < 4; s++) begin
          @(negedge CLK);
          check("stall_in_ready", IN_READY, 0);
          check("stall_out_valid", OUT_VALID, 1);
          check("stall_hold", $signed(OUT_RE), $signed(hold_re));
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_count", rx_cnt - rx_before, 8);

    // reset with one result at the output and two in flight
    send(10, 20, 16384, 0, 1'b0, 10, 20);
    send(30, 40, 16384, 0, 1'b0, 30, 40);
    send(50, 60, 16384, 0, 1'b0, 50, 60);
    check("rst_pre_valid", OUT_VALID, 1);
    RST_X = 1'b0;
    #1;
    check("rst_mid_valid", OUT_VALID, 0);
    check("rst_mid_re", OUT_RE, 0);
    check("rst_mid_im", OUT_IM, 0);
    check("rst_mid_ovf", OVF, 0);
    exp_q.delete();
    acc_q.delete();
    seen_before = out_seen;
    repeat (2) @(posedge CLK);
    #1;
    RST_X = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    check("rst_no_stale", out_seen - seen_before, 0);

    lat_on = 1'b1;
    send(-700, 900, 16384, 0, 1'b1, -700, 900);
    drain("drain_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_cmult_pipe.md
# fft_cmult_pipe

Pipelined, parametrised complex multiplier for the FFT butterfly datapath: multiplies a complex sample by a full-precision fixed-point twiddle factor (not limited to ±1/±j), with optional conjugation for inverse transforms. Rounds and saturates the result back to sample width. Carries a valid/ready handshake with backpressure so it can sit between the sample buffer and the butterfly adder stage.

## Interface
- DW, 33: sample width (signed, per real/imag component)
- TW, 16: twiddle width (signed, Q2.(TW-2); +1.0 = 2^(TW-2))
- FRAC, TW-2: fractional bits removed after multiply
- CLK  in  1  clock, all logic on rising edge
- RST_X  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  input sample/twiddle valid
- IN_READY  out  1  block can accept input this cycle
- IN_RE, IN_IM  in  DW  signed sample
- W_RE, W_IM  in  TW  signed twiddle
- CONJ  in  1  1 = use conj(W) (inverse FFT), sampled with input
- OUT_VALID  out  1  result valid
- OUT_READY  in  1  downstream accepts result
- OUT_RE, OUT_IM  out  DW  signed rounded/saturated result
- OVF  out  1  sticky: any saturation since reset or CLR
- CLR  in  1  synchronous clear of OVF

## Operation
- Result: OUT = IN × W (CONJ=0) or IN × conj(W) (CONJ=1).
- CONJ applied as W_IM negation in stage 1; -(-2^(TW-1)) saturates to 2^(TW-1)-1.
- Products are DW+TW bits; sums/differences DW+TW+1 bits, no intermediate truncation.
- Rounding: add 2^(FRAC-1), arithmetic shift right FRAC (round half toward +∞).
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1]; each clamp sets OVF on the cycle the result enters stage 3.
- CLR and a saturation event in the same cycle: OVF ends 1 (set wins).
- Pipeline: S1 registers inputs (with conj); S2 registers four real products; S3 registers combined, rounded, saturated result. Each stage carries a valid bit.
- Enable EN = OUT_READY | ~OUT_VALID; all stages advance only when EN=1 (whole-pipe stall, no bubble collapse).
- IN_READY = EN (combinational). Transfer on IN_VALID & IN_READY; OUT transfer on OUT_VALID & OUT_READY.
- Data registers need not be reset; valid bits, OUT_RE/OUT_IM and OVF are.

## Timing
- Reset values: OUT_VALID=0, OUT_RE=0, OUT_IM=0, OVF=0, all stage valids 0; IN_READY=1 after reset.
- Latency: 3 cycles from accepted input to OUT_VALID with OUT_READY held high; throughput 1 per cycle.
- OUT_READY low while OUT_VALID=1: OUT_* and all stages hold; IN_READY=0 same cycle.
- OUT_VALID held with stable data until accepted.
- Reset asserted mid-operation: all in-flight results discarded, outputs return to reset values immediately.

## Structure
- Shared package fft_pkg: default DW/TW/FRAC, twiddle ONE constant (2^(TW-2)), saturation bound helpers.
- One sub-module: cmult_round_sat (round + saturate + overflow flag), instantiated twice (real, imag).

## Test plan
- Identity: IN=(1000,-2000), W=(16384,0), CONJ=0 -> OUT=(1000,-2000) 3 cycles later, OVF=0.
- Rotation: IN=(500,300), W=(0,16384): CONJ=0 -> (-300,500); CONJ=1 -> (300,-500).
- Rounding: IN=(1,0), W=(8192,0) -> (1,0); IN=(-1,0), W=(8192,0) -> (0,0); IN=(3,0), W=(-8192,0) -> (-1,0).
- Saturation: IN=(2^32-1, 2^32-1), W=(16384,-16384) -> OUT_RE=2^32-1, OVF=1 sticky until CLR pulse, then 0.
- Backpressure: stream 8 back-to-back inputs, drop OUT_READY for 4 cycles mid-stream -> IN_READY=0 during stall, all 8 results in order, none lost or duplicated.
- Reset mid-stream: assert RST_X=0 with 2 results in flight -> OUT_VALID=0 at once, no stale outputs after release.
